// File: rtl/axi4_sram_slave.sv
// AXI4 slave terminating single-beat traffic on a 64-bit synchronous SRAM.
// Reads and writes share one FSM. Out-of-window, multi-beat or oversized
// requests complete with SLVERR and never strobe the SRAM.
module axi4_sram_slave #(
  parameter int unsigned TAG       = 1,
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'hf010_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [TAG-1:0]    axi_awid,
  input  logic [31:0]       axi_awaddr,
  input  logic [2:0]        axi_awsize,
  input  logic [7:0]        axi_awlen,
  input  logic [1:0]        axi_awburst,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  input  logic [63:0]       axi_wdata,
  input  logic [7:0]        axi_wstrb,
  input  logic              axi_wlast,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  output logic [TAG-1:0]    axi_bid,
  output logic [1:0]        axi_bresp,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  input  logic [TAG-1:0]    axi_arid,
  input  logic [31:0]       axi_araddr,
  input  logic [2:0]        axi_arsize,
  input  logic [7:0]        axi_arlen,
  input  logic [1:0]        axi_arburst,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  output logic [TAG-1:0]    axi_rid,
  output logic [63:0]       axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rlast,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [63:0]       sram_wdata,
  output logic [7:0]        sram_wbe,
  input  logic [63:0]       sram_rdata
);

  localparam int unsigned WIN_LSB = ADDR_W + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_WRESP, S_RDWAIT, S_RRESP, S_RERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_init;
  logic               r_last_wr;
  logic [TAG-1:0]     r_id;
  logic [ADDR_W-1:0]  r_waddr;
  logic [7:0]         r_cnt;
  logic               r_err;
  logic [63:0]        r_rbuf;

  logic w_idle, w_awready, w_arready, w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
  logic w_aw_err, w_ar_err;
  logic w_unused;

  assign w_idle    = (r_state == S_IDLE);
  // Tie break: a pending read wins only if the previous grant was a write.
  assign w_awready = w_idle & r_init & (~axi_arvalid | ~r_last_wr);
  assign w_arready = w_idle & r_init & (~axi_awvalid |  r_last_wr);
  assign w_aw_hs   = axi_awvalid & w_awready;
  assign w_ar_hs   = axi_arvalid & w_arready;
  assign w_w_hs    = axi_wvalid & (r_state == S_WDATA);
  assign w_r_hs    = axi_rready & axi_rvalid;

  assign w_aw_err  = (axi_awaddr[31:WIN_LSB] != BASE_ADDR[31:WIN_LSB]) |
                     (axi_awlen != 8'd0) | (axi_awsize > 3'd3);
  assign w_ar_err  = (axi_araddr[31:WIN_LSB] != BASE_ADDR[31:WIN_LSB]) |
                     (axi_arlen != 8'd0) | (axi_arsize > 3'd3);

  assign w_unused  = ^{axi_awburst, axi_arburst, axi_wlast,
                       axi_awaddr[2:0], axi_araddr[2:0]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Captured request attributes, beat counter, grant history and read buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init    <= 1'b0;
      r_last_wr <= 1'b0;
      r_id      <= '0;
      r_waddr   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rbuf    <= '0;
    end else begin
      r_init <= 1'b1;
      if (w_aw_hs) begin
        r_last_wr <= 1'b1;
        r_id      <= axi_awid;
        r_waddr   <= axi_awaddr[ADDR_W+2:3];
        r_cnt     <= axi_awlen;
        r_err     <= w_aw_err;
      end else if (w_ar_hs) begin
        r_last_wr <= 1'b0;
        r_id      <= axi_arid;
        r_cnt     <= axi_arlen;
        r_err     <= w_ar_err;
      end else if (w_w_hs || (w_r_hs && r_state == S_RERR)) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (r_state == S_RDWAIT) r_rbuf <= sram_rdata;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_aw_hs)      w_next = S_WDATA;
        else if (w_ar_hs) w_next = w_ar_err ? S_RERR : S_RDWAIT;
      end
      S_WDATA:  if (axi_wvalid && r_cnt == 8'd0) w_next = S_WRESP;
      S_WRESP:  if (axi_bready) w_next = S_IDLE;
      S_RDWAIT: w_next = S_RRESP;
      S_RRESP:  if (axi_rready) w_next = S_IDLE;
      S_RERR:   if (axi_rready && r_cnt == 8'd0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output decode; every output idles at zero, SRAM fields only carry data while strobed.
  always_comb begin
    axi_awready = w_awready;
    axi_arready = w_arready;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bid     = '0;
    axi_bresp   = 2'b00;
    axi_rvalid  = 1'b0;
    axi_rid     = '0;
    axi_rdata   = '0;
    axi_rresp   = 2'b00;
    axi_rlast   = 1'b0;
    sram_cs     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    sram_wbe    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_ar_hs && !w_ar_err) begin
          sram_cs   = 1'b1;
          sram_addr = axi_araddr[ADDR_W+2:3];
        end
      end
      S_WDATA: begin
        axi_wready = 1'b1;
        if (axi_wvalid && !r_err) begin
          sram_cs    = 1'b1;
          sram_we    = 1'b1;
          sram_addr  = r_waddr;
          sram_wdata = axi_wdata;
          sram_wbe   = axi_wstrb;
        end
      end
      S_WRESP: begin
        axi_bvalid = 1'b1;
        axi_bid    = r_id;
        axi_bresp  = r_err ? 2'b10 : 2'b00;
      end
      S_RRESP: begin
        axi_rvalid = 1'b1;
        axi_rid    = r_id;
        axi_rdata  = r_rbuf;
        axi_rlast  = 1'b1;
      end
      S_RERR: begin
        axi_rvalid = 1'b1;
        axi_rid    = r_id;
        axi_rresp  = 2'b10;
        axi_rlast  = (r_cnt == 8'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave with a registered SRAM model.
module tb_axi4_sram_slave;

  localparam int unsigned TAG    = 1;
  localparam int unsigned ADDR_W = 12;
  localparam logic [31:0] BASE   = 32'hf010_0000;
  localparam logic [63:0] JUNK   = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] WDAT   = 64'h1122_3344_5566_7788;
  localparam logic [63:0] SEED3  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] EXP3   = 64'hAAAA_BBBB_5566_7788;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic axi_awvalid, axi_awready; logic [TAG-1:0] axi_awid; logic [31:0] axi_awaddr;
  logic [2:0] axi_awsize; logic [7:0] axi_awlen; logic [1:0] axi_awburst;
  logic axi_wvalid, axi_wready; logic [63:0] axi_wdata; logic [7:0] axi_wstrb; logic axi_wlast;
  logic axi_bvalid, axi_bready; logic [TAG-1:0] axi_bid; logic [1:0] axi_bresp;
  logic axi_arvalid, axi_arready; logic [TAG-1:0] axi_arid; logic [31:0] axi_araddr;
  logic [2:0] axi_arsize; logic [7:0] axi_arlen; logic [1:0] axi_arburst;
  logic axi_rvalid, axi_rready; logic [TAG-1:0] axi_rid; logic [63:0] axi_rdata;
  logic [1:0] axi_rresp; logic axi_rlast;
  logic sram_cs, sram_we; logic [ADDR_W-1:0] sram_addr; logic [63:0] sram_wdata;
  logic [7:0] sram_wbe; logic [63:0] sram_rdata;

  logic [63:0] mem [0:(1<<ADDR_W)-1];
  logic        seeded = 1'b0;
  int          cs_count = 0;
  int          total = 0;
  int          bad = 0;
  int          cs_before;
  logic [255:0] outs;

  assign outs = {axi_awready, axi_wready, axi_bvalid, axi_bid, axi_bresp, axi_arready,
                 axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast, sram_cs, sram_we,
                 sram_addr, sram_wdata, sram_wbe};

  axi4_sram_slave #(.TAG(TAG), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awsize(axi_awsize), .axi_awlen(axi_awlen),
    .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arsize(axi_arsize), .axi_arlen(axi_arlen),
    .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wbe(sram_wbe), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-masked writes, read data valid only the cycle after a read strobe.
  always @(posedge clk) begin
    if (rst && !seeded) begin
      mem[3] <= SEED3;
      mem[2] <= '0;
      seeded <= 1'b1;
    end
    if (sram_cs && sram_we)
      for (int b = 0; b < 8; b++)
        if (sram_wbe[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    sram_rdata <= (sram_cs && !sram_we) ? mem[sram_addr] : JUNK;
    if (sram_cs) cs_count <= cs_count + 1;
  end

  task automatic test_reset;
    axi_awvalid = 1; axi_arvalid = 1; axi_wvalid = 1; axi_bready = 1; axi_rready = 1;
    axi_awaddr = BASE; axi_araddr = BASE;
    repeat (2) @(negedge clk);
    #1;
    total++; if (outs !== '0) begin bad++; $display("FAIL rst_outs got=%h want=0", outs); end
    rst = 0; #1;
    total++; if (outs !== '0) begin bad++; $display("FAIL rst_release_outs got=%h want=0", outs); end
    @(negedge clk);
    axi_awvalid = 0; axi_arvalid = 0; axi_bready = 0; axi_rready = 0; #1;
    total++; if ({axi_awready, axi_arready, axi_wready} !== 3'b110) begin
      bad++; $display("FAIL idle_ready got=%b want=110", {axi_awready, axi_arready, axi_wready}); end
    axi_wvalid = 0;
  endtask

  task automatic test_write_ok;
    axi_awvalid = 1; axi_awid = 1'b1; axi_awaddr = BASE + 32'h18; axi_awsize = 3; axi_awlen = 0;
    axi_wvalid = 1; axi_wdata = WDAT; axi_wstrb = 8'h0F; #1;
    total++; if ({axi_awready, axi_wready, sram_cs} !== 3'b100) begin
      bad++; $display("FAIL wr_aw_cycle got=%b want=100", {axi_awready, axi_wready, sram_cs}); end
    @(negedge clk);
    axi_awvalid = 0; #1;
    total++; if ({axi_wready, sram_cs, sram_we, axi_bvalid} !== 4'b1110) begin
      bad++; $display("FAIL wr_w_ctrl got=%b want=1110", {axi_wready, sram_cs, sram_we, axi_bvalid}); end
    total++; if (sram_addr !== 12'd3) begin bad++; $display("FAIL wr_addr got=%0d want=3", sram_addr); end
    total++; if (sram_wbe !== 8'h0F || sram_wdata !== WDAT) begin
      bad++; $display("FAIL wr_data got=%h/%h want=0f/%h", sram_wbe, sram_wdata, WDAT); end
    @(negedge clk);
    axi_wvalid = 0; #1;
    total++; if ({axi_bvalid, axi_bresp, axi_bid, axi_wready} !== 5'b10010) begin
      bad++; $display("FAIL wr_b got=%b want=10010", {axi_bvalid, axi_bresp, axi_bid, axi_wready}); end
    @(negedge clk); #1;
    total++; if (axi_bvalid !== 1'b1) begin bad++; $display("FAIL wr_b_hold got=%b want=1", axi_bvalid); end
    axi_bready = 1;
    @(negedge clk);
    axi_bready = 0; #1;
    total++; if ({axi_bvalid, axi_awready} !== 2'b01) begin
      bad++; $display("FAIL wr_done got=%b want=01", {axi_bvalid, axi_awready}); end
    total++; if (mem[3] !== EXP3) begin bad++; $display("FAIL wr_mem got=%h want=%h", mem[3], EXP3); end
  endtask

  task automatic test_read_ok;
    axi_arvalid = 1; axi_arid = 1'b0; axi_araddr = BASE + 32'h18; axi_arsize = 3; axi_arlen = 0; #1;
    total++; if ({axi_arready, sram_cs, sram_we} !== 3'b110 || sram_addr !== 12'd3) begin
      bad++; $display("FAIL rd_ar_cycle got=%b/%0d want=110/3", {axi_arready, sram_cs, sram_we}, sram_addr); end
    @(negedge clk);
    axi_arvalid = 0; #1;
    total++; if ({axi_rvalid, sram_cs} !== 2'b00) begin
      bad++; $display("FAIL rd_wait got=%b want=00", {axi_rvalid, sram_cs}); end
    @(negedge clk); #1;
    total++; if ({axi_rvalid, axi_rlast, axi_rresp, axi_rid} !== 5'b11000) begin
      bad++; $display("FAIL rd_r_ctrl got=%b want=11000", {axi_rvalid, axi_rlast, axi_rresp, axi_rid}); end
    total++; if (axi_rdata !== EXP3) begin bad++; $display("FAIL rd_data got=%h want=%h", axi_rdata, EXP3); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++; if ({axi_rvalid, axi_rdata} !== {1'b1, EXP3}) begin
        bad++; $display("FAIL rd_stall%0d got=%b/%h want=1/%h", i, axi_rvalid, axi_rdata, EXP3); end
    end
    axi_rready = 1;
    @(negedge clk);
    axi_rready = 0; #1;
    total++; if ({axi_rvalid, axi_arready} !== 2'b01) begin
      bad++; $display("FAIL rd_done got=%b want=01", {axi_rvalid, axi_arready}); end
  endtask

  task automatic test_read_err;
    logic [31:0] addrs [2];
    logic [2:0]  sizes [2];
    addrs[0] = BASE + 32'h8000; sizes[0] = 3;
    addrs[1] = BASE + 32'h18;   sizes[1] = 4;
    cs_before = cs_count;
    for (int k = 0; k < 2; k++) begin
      axi_arvalid = 1; axi_arid = 1'b1; axi_araddr = addrs[k]; axi_arsize = sizes[k]; axi_arlen = 0; #1;
      total++; if ({axi_arready, sram_cs} !== 2'b10) begin
        bad++; $display("FAIL rderr%0d_ar got=%b want=10", k, {axi_arready, sram_cs}); end
      @(negedge clk);
      axi_arvalid = 0; #1;
      total++; if ({axi_rvalid, axi_rresp, axi_rlast, axi_rid} !== 5'b11011 || axi_rdata !== '0) begin
        bad++; $display("FAIL rderr%0d_r got=%b/%h want=11011/0", k,
                        {axi_rvalid, axi_rresp, axi_rlast, axi_rid}, axi_rdata); end
      axi_rready = 1;
      @(negedge clk);
      axi_rready = 0; #1;
      total++; if (axi_rvalid !== 1'b0) begin bad++; $display("FAIL rderr%0d_done got=%b want=0", k, axi_rvalid); end
    end
    total++; if (cs_count !== cs_before) begin
      bad++; $display("FAIL rderr_no_cs got=%0d want=%0d", cs_count, cs_before); end
  endtask

  task automatic test_write_err_burst;
    cs_before = cs_count;
    axi_awvalid = 1; axi_awid = 1'b0; axi_awaddr = BASE + 32'h20; axi_awsize = 3; axi_awlen = 3; #1;
    total++; if (axi_awready !== 1'b1) begin bad++; $display("FAIL wrerr_aw got=%b want=1", axi_awready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      axi_awvalid = 0; axi_wvalid = 1; axi_wdata = 64'(i); axi_wstrb = 8'hFF; #1;
      total++; if ({axi_wready, sram_cs, axi_bvalid} !== 3'b100) begin
        bad++; $display("FAIL wrerr_beat%0d got=%b want=100", i, {axi_wready, sram_cs, axi_bvalid}); end
    end
    @(negedge clk);
    axi_wvalid = 0; #1;
    total++; if ({axi_bvalid, axi_bresp, axi_bid, axi_wready} !== 5'b11000) begin
      bad++; $display("FAIL wrerr_b got=%b want=11000", {axi_bvalid, axi_bresp, axi_bid, axi_wready}); end
    axi_bready = 1;
    @(negedge clk);
    axi_bready = 0; #1;
    total++; if (axi_bvalid !== 1'b0) begin bad++; $display("FAIL wrerr_single_b got=%b want=0", axi_bvalid); end
    axi_arvalid = 1; axi_arid = 1'b1; axi_araddr = BASE + 32'h18; axi_arsize = 3; axi_arlen = 2; #1;
    total++; if ({axi_arready, sram_cs} !== 2'b10) begin
      bad++; $display("FAIL rdlen_ar got=%b want=10", {axi_arready, sram_cs}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      axi_arvalid = 0; axi_rready = 1; #1;
      total++; if ({axi_rvalid, axi_rresp, axi_rlast} !== {3'b110, (i == 2)} || axi_rdata !== '0) begin
        bad++; $display("FAIL rdlen_beat%0d got=%b/%h want=%b/0", i,
                        {axi_rvalid, axi_rresp, axi_rlast}, axi_rdata, {3'b110, (i == 2)}); end
    end
    @(negedge clk);
    axi_rready = 0; #1;
    total++; if (axi_rvalid !== 1'b0) begin bad++; $display("FAIL rdlen_done got=%b want=0", axi_rvalid); end
    total++; if (cs_count !== cs_before) begin
      bad++; $display("FAIL wrerr_no_cs got=%0d want=%0d", cs_count, cs_before); end
  endtask

  task automatic test_back_to_back;
    logic want_w;
    axi_awid = 1'b0; axi_awaddr = BASE + 32'h10; axi_awsize = 3; axi_awlen = 0;
    axi_arid = 1'b0; axi_araddr = BASE + 32'h18; axi_arsize = 3; axi_arlen = 0;
    for (int t = 0; t < 4; t++) begin
      want_w = (t % 2 == 0);
      axi_awvalid = 1; axi_arvalid = 1; #1;
      total++; if ({axi_awready, axi_arready} !== {want_w, !want_w}) begin
        bad++; $display("FAIL tie%0d_grant got=%b want=%b", t, {axi_awready, axi_arready}, {want_w, !want_w}); end
      @(negedge clk);
      if (want_w) begin
        axi_awvalid = 0; axi_wvalid = 1; axi_wdata = 64'(t); axi_wstrb = 8'hFF;
        @(negedge clk);
        axi_wvalid = 0; axi_bready = 1; #1;
        total++; if ({axi_bvalid, axi_bresp} !== 3'b100) begin
          bad++; $display("FAIL tie%0d_b got=%b want=100", t, {axi_bvalid, axi_bresp}); end
        @(negedge clk);
        axi_bready = 0;
      end else begin
        axi_arvalid = 0;
        @(negedge clk);
        axi_rready = 1; #1;
        total++; if ({axi_rvalid, axi_rresp} !== 3'b100 || axi_rdata !== EXP3) begin
          bad++; $display("FAIL tie%0d_r got=%b/%h want=100/%h", t, {axi_rvalid, axi_rresp}, axi_rdata, EXP3); end
        @(negedge clk);
        axi_rready = 0;
      end
    end
    axi_awvalid = 0; axi_arvalid = 0; #1;
    total++; if (mem[2] !== 64'd2) begin bad++; $display("FAIL tie_mem got=%h want=2", mem[2]); end
  endtask

  task automatic test_reset_mid;
    axi_arvalid = 1; axi_arid = 1'b1; axi_araddr = BASE + 32'h18; axi_arsize = 3; axi_arlen = 0; #1;
    total++; if ({axi_arready, sram_cs} !== 2'b11) begin
      bad++; $display("FAIL mid_ar got=%b want=11", {axi_arready, sram_cs}); end
    @(negedge clk);
    axi_arvalid = 0; #1;
    rst = 1; #1;
    total++; if (outs !== '0) begin bad++; $display("FAIL mid_rst_outs got=%h want=0", outs); end
    @(negedge clk); #1;
    rst = 0; #1;
    total++; if (outs !== '0) begin bad++; $display("FAIL mid_release_outs got=%h want=0", outs); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total++; if (axi_rvalid !== 1'b0) begin bad++; $display("FAIL mid_no_r%0d got=%b want=0", i, axi_rvalid); end
    end
    axi_arvalid = 1; axi_arid = 1'b0; #1;
    total++; if ({axi_arready, sram_cs, sram_we} !== 3'b110) begin
      bad++; $display("FAIL post_ar got=%b want=110", {axi_arready, sram_cs, sram_we}); end
    @(negedge clk);
    axi_arvalid = 0;
    @(negedge clk); #1;
    total++; if ({axi_rvalid, axi_rlast, axi_rresp} !== 4'b1100 || axi_rdata !== EXP3) begin
      bad++; $display("FAIL post_r got=%b/%h want=1100/%h", {axi_rvalid, axi_rlast, axi_rresp}, axi_rdata, EXP3); end
    axi_rready = 1;
    @(negedge clk);
    axi_rready = 0;
  endtask

  initial begin
    axi_awvalid = 0; axi_awid = '0; axi_awaddr = '0; axi_awsize = '0; axi_awlen = '0; axi_awburst = 2'b01;
    axi_wvalid = 0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b1; axi_bready = 0;
    axi_arvalid = 0; axi_arid = '0; axi_araddr = '0; axi_arsize = '0; axi_arlen = '0; axi_arburst = 2'b01;
    axi_rready = 0;
    test_reset();
    test_write_ok();
    test_read_ok();
    test_read_err();
    test_write_err_burst();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
